// File: rtl/pipe_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_pkg
//   Shared definitions for the pipeline stage register family:
//     - stage_state_e : occupancy state of one stage register (EMPTY/ONE/FULL2)
//     - default control/data widths for each CPU stage boundary
//     - state_occupancy(): number of entries held in a given state
// -----------------------------------------------------------------------------
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing held, out_valid low
    ST_ONE   = 2'd1,  // main register holds the head entry
    ST_FULL2 = 2'd2   // main holds the head, skid holds the next entry
  } stage_state_e;

  // ID/EX: regwrite, memtoreg, branch, jump, memread, memwrite, alusrc, aluop[1:0]
  localparam int ID_EX_CTRL_W  = 9;
  // ID/EX: read1 32 + read2 32 + imm 32 + rt 5 + rd 5
  localparam int ID_EX_DATA_W  = 106;
  // EX/MEM: jump, branch, memread, memwrite, regwrite, memtoreg
  localparam int EX_MEM_CTRL_W = 6;
  // EX/MEM: aluResult 32 + read2 32 + regDst 5
  localparam int EX_MEM_DATA_W = 69;
  // MEM/WB: regwrite, memtoreg
  localparam int MEM_WB_CTRL_W = 2;
  // MEM/WB: readData 32 + aluResult 32 + regDst 5
  localparam int MEM_WB_DATA_W = 69;

  function automatic logic [1:0] state_occupancy(input stage_state_e st);
    case (st)
      ST_ONE:   return 2'd1;
      ST_FULL2: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
//   valid/ready handshake bundle carrying one pipeline entry.
//   Signals:
//     valid  producer presents an entry
//     ready  consumer accepts the entry this cycle
//     ctrl   control bits (CTRL_W)
//     data   data bits (DATA_W)
//   Modports:
//     master  producer side (drives valid/ctrl/data, samples ready)
//     slave   consumer side (drives ready, samples valid/ctrl/data)
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 6,
  parameter int DATA_W = 69
);

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input  ready);
  modport slave  (input  valid, input  ctrl, input  data, output ready);

endinterface

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Parametrised pipeline stage register between two CPU stages. Entries move
//   with a valid/ready handshake and appear downstream one cycle after they are
//   accepted. With SKID=1 a second (skid) register lets in_ready be a pure
//   register decode, cutting the combinational ready path from downstream.
//   With SKID=0 only the main register exists and in_ready depends on out_ready.
//
// Parameters
//   CTRL_W  control field width, forced to 0 on bubbles
//   DATA_W  data field width
//   SKID    1 = two entries, registered in_ready; 0 = one entry, comb in_ready
//
// Ports
//   clk        rising-edge clock
//   startin_n  synchronous active-low reset
//   flush      synchronous discard of all held entries (taken branch/jump)
//   up         upstream side   (in_valid/in_ready/in_ctrl/in_data)
//   dn         downstream side (out_valid/out_ready/out_ctrl/out_data)
//   occupancy  number of entries currently held (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int          CTRL_W = EX_MEM_CTRL_W,
  parameter int          DATA_W = EX_MEM_DATA_W,
  parameter int unsigned SKID   = 1
) (
  input  logic                   clk,
  input  logic                   startin_n,
  input  logic                   flush,
  pipe_stage_reg_if.slave        up,
  pipe_stage_reg_if.master       dn,
  output logic [1:0]             occupancy
);

  stage_state_e      state;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic accept;   // entry enters the stage at this edge
  logic deliver;  // head entry leaves the stage at this edge

  assign dn.valid  = (state != ST_EMPTY);
  // Bubbles must never carry write/branch enables, so gate the control field.
  assign dn.ctrl   = dn.valid ? main_ctrl : '0;
  assign dn.data   = main_data;
  assign occupancy = state_occupancy(state);

  generate
    if (SKID != 0) begin : g_skid_ready
      // Pure state decode: downstream ready never reaches upstream in one cycle.
      assign up.ready = (state != ST_FULL2);
    end else begin : g_comb_ready
      // Single entry: a slot frees up in the same cycle the head is consumed.
      assign up.ready = (state == ST_EMPTY) | dn.ready;
    end
  endgenerate

  assign accept  = up.valid & up.ready;
  assign deliver = dn.valid & dn.ready;

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of the others; blocking = would make the skid->main move
  // order-dependent.
  always_ff @(posedge clk) begin
    if (!startin_n) begin
      // NOTE: data registers are reset too, so out_data reads 0 after reset
      // instead of X; these are single registers, not a RAM array.
      state     <= ST_EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      // Same-cycle input is dropped; a same-cycle output transfer has already
      // been seen downstream. Data is left as-is, only ctrl is scrubbed.
      state     <= ST_EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      // NOTE: the default arm closes the case so no path leaves state
      // unassigned; unreachable encodings recover to EMPTY.
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_ctrl <= up.ctrl;
            main_data <= up.data;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && deliver) begin
            main_ctrl <= up.ctrl;
            main_data <= up.data;
          end else if (deliver) begin
            state <= ST_EMPTY;
          end else if (accept && (SKID != 0)) begin
            // Head is stalled: park the new entry behind it.
            skid_ctrl <= up.ctrl;
            skid_data <= up.data;
            state     <= ST_FULL2;
          end
        end
        ST_FULL2: begin
          // in_ready is low here, so only the skid->main move can happen.
          if (deliver) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            state     <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule
